// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor:
//   - MODE encodings (static not-taken / bimodal counter table)
//   - saturating counter limits and reset value as functions of counter width
//   - a single saturating step function used by both the table counters and
//     the lookup bypass path, so the two can never disagree
// Counters are carried in a fixed 4-bit container (ctr_t); callers cast down
// to their actual CTR_W.
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int CTR_W_MAX = 4;

    typedef logic [CTR_W_MAX-1:0] ctr_t;

    // MODE parameter encodings
    localparam int MODE_STATIC  = 0;
    localparam int MODE_BIMODAL = 1;

    // Saturation ceiling for a w-bit counter: 2**w - 1
    function automatic ctr_t ctr_max(input int w);
        ctr_t m;
        m = '0;
        for (int b = 0; b < CTR_W_MAX; b++) begin
            if (b < w) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

    // Saturation floor
    function automatic ctr_t ctr_min();
        return '0;
    endfunction

    // Weakly-not-taken: 2**(w-1) - 1, i.e. the ceiling shifted right by one
    function automatic ctr_t ctr_reset_val(input int w);
        return ctr_max(w) >> 1;
    endfunction

    // One saturating step towards taken (up=1) or not-taken (up=0)
    function automatic ctr_t ctr_step(input ctr_t cur, input logic up, input int w);
        ctr_t r;
        r = cur;
        if (up) begin
            if (cur != ctr_max(w)) begin
                r = cur + ctr_t'(1);
            end
        end else begin
            if (cur != ctr_min()) begin
                r = cur - ctr_t'(1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// One CTR_W-bit saturating up/down counter, one entry of the prediction table.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset to weakly-not-taken
//   en     in   apply one step this cycle
//   up     in   step direction: 1 = towards taken, 0 = towards not-taken
//   count  out  current counter value
// Reset has priority over en, so an update in the reset cycle is dropped.
// -----------------------------------------------------------------------------
module sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    output logic [CTR_W-1:0] count
);

    logic [CTR_W-1:0] count_q;
    logic [CTR_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = CTR_W'(ctr_step(ctr_t'(count_q), up, CTR_W));
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= CTR_W'(ctr_reset_val(CTR_W));
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Untagged bimodal branch predictor with resolution statistics.
// Parameters:
//   IDX_W   table index width (2**IDX_W entries)
//   CTR_W   saturating counter width, 1..4
//   MODE    0 = static not-taken, 1 = bimodal counter table
//   STAT_W  statistics counter width
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   pc, is_branch           decode-stage lookup
//   past_pc, past_is_branch execute-stage resolution
//   past_wrong              execute branch was mispredicted
//   past_predicted_taken    prediction that was made for the execute branch
//   shouldTakeBranch        zero-latency prediction for the decode branch
//   branch_count            resolved branches (saturating)
//   mispredict_count        resolved mispredictions (saturating)
// Handshake: none. A lookup is valid whenever is_branch=1 and is answered in
// the same cycle; an update is presented whenever past_is_branch=1 and is
// consumed on that rising edge (no backpressure).
// -----------------------------------------------------------------------------
module branch_predictor
    import bp_pkg::*;
#(
    parameter int IDX_W  = 6,
    parameter int CTR_W  = 2,
    parameter int MODE   = 1,
    parameter int STAT_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic              is_branch,
    input  logic [31:0]       past_pc,
    input  logic              past_is_branch,
    input  logic              past_wrong,
    input  logic              past_predicted_taken,
    output logic              shouldTakeBranch,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int ENTRIES = 1 << IDX_W;

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             actual_taken;
    logic [CTR_W-1:0] table_count [ENTRIES];
    logic [CTR_W-1:0] rd_count;
    logic [CTR_W-1:0] lookup_count;
    logic             bypass_hit;

    // Only the low index bits participate; the rest of each PC is ignored.
    assign rd_idx = pc[IDX_W-1:0];
    assign wr_idx = past_pc[IDX_W-1:0];

    logic unused_pc_hi;
    assign unused_pc_hi = ^{pc[31:IDX_W], past_pc[31:IDX_W]};

    // A mispredicted branch went the opposite way from its prediction.
    assign actual_taken = past_predicted_taken ^ past_wrong;

    // ------------------------------------------------------------------
    // Counter table, one flop-based counter per entry so reset clears the
    // whole table in a single edge.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < ENTRIES; i++) begin : g_table
        logic entry_en;
        assign entry_en = past_is_branch && (wr_idx == IDX_W'(i));

        sat_counter #(
            .CTR_W (CTR_W)
        ) u_ctr (
            .clock (clock),
            .reset (reset),
            .en    (entry_en),
            .up    (actual_taken),
            .count (table_count[i])
        );
    end

    // ------------------------------------------------------------------
    // Lookup with write-to-read bypass: when the entry being read is being
    // updated on this edge, predict from the value it is about to take.
    // During reset the update is discarded, so no bypass either.
    // ------------------------------------------------------------------
    assign rd_count   = table_count[rd_idx];
    assign bypass_hit = past_is_branch && !reset && (rd_idx == wr_idx);

    always_comb begin
        lookup_count = rd_count;
        if (bypass_hit) begin
            lookup_count = CTR_W'(ctr_step(ctr_t'(rd_count), actual_taken, CTR_W));
        end
    end

    assign shouldTakeBranch = is_branch && (MODE == MODE_BIMODAL) && lookup_count[CTR_W-1];

    // ------------------------------------------------------------------
    // Statistics, kept in every MODE.
    // ------------------------------------------------------------------
    logic [STAT_W-1:0] branch_count_q;
    logic [STAT_W-1:0] branch_count_d;
    logic [STAT_W-1:0] mispredict_count_q;
    logic [STAT_W-1:0] mispredict_count_d;

    always_comb begin
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;
        if (past_is_branch) begin
            if (!(&branch_count_q)) begin
                branch_count_d = branch_count_q + STAT_W'(1);
            end
            if (past_wrong && !(&mispredict_count_q)) begin
                mispredict_count_d = mispredict_count_q + STAT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign branch_count     = branch_count_q;
    assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Two predictors driven from the same stimulus: dut_a in bimodal mode and
// dut_b in static not-taken mode. The driver pushes one expected record per
// checked cycle; the monitor pops it at the falling edge and compares.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    localparam int W = 8 + 1 + 16 + 16;  // {tag, pred, branch_count, mispredict_count}

    // ---------------- clock / reset ----------------
    logic clock;
    logic reset;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- DUT signals ----------------
    logic [31:0] pc;
    logic        is_branch;
    logic [31:0] past_pc;
    logic        past_is_branch;
    logic        past_wrong;
    logic        past_predicted_taken;
    logic        pred_a;
    logic        pred_b;
    logic [15:0] bc_a;
    logic [15:0] mc_a;
    logic [15:0] bc_b;
    logic [15:0] mc_b;

    branch_predictor #(.IDX_W(6), .CTR_W(2), .MODE(1), .STAT_W(16)) dut_a (
        .clock                (clock),
        .reset                (reset),
        .pc                   (pc),
        .is_branch            (is_branch),
        .past_pc              (past_pc),
        .past_is_branch       (past_is_branch),
        .past_wrong           (past_wrong),
        .past_predicted_taken (past_predicted_taken),
        .shouldTakeBranch     (pred_a),
        .branch_count         (bc_a),
        .mispredict_count     (mc_a)
    );

    branch_predictor #(.IDX_W(6), .CTR_W(2), .MODE(0), .STAT_W(16)) dut_b (
        .clock                (clock),
        .reset                (reset),
        .pc                   (pc),
        .is_branch            (is_branch),
        .past_pc              (past_pc),
        .past_is_branch       (past_is_branch),
        .past_wrong           (past_wrong),
        .past_predicted_taken (past_predicted_taken),
        .shouldTakeBranch     (pred_b),
        .branch_count         (bc_b),
        .mispredict_count     (mc_b)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    logic         chk_v;
    int           total;
    int           bad;
    int           tag_n;
    logic [15:0]  exp_bc;
    logic [15:0]  exp_mc;

    task automatic check_field(input string nm, input int tag, input logic [15:0] act,
                               input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s tag=%0d got=%0h want=%0h", nm, tag, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (chk_v) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow got=0 want=1");
            end else begin
                logic [W-1:0] e;
                int           t;
                e = exp_q.pop_front();
                t = int'(e[40:33]);
                check_field("pred_a", t, {15'd0, pred_a}, {15'd0, e[32]});
                check_field("pred_b", t, {15'd0, pred_b}, 16'd0);
                check_field("bcnt_a", t, bc_a, e[31:16]);
                check_field("mcnt_a", t, mc_a, e[15:0]);
                check_field("bcnt_b", t, bc_b, e[31:16]);
                check_field("mcnt_b", t, mc_b, e[15:0]);
            end
        end
    end

    // ---------------- driver ----------------
    // Applies one cycle of inputs. When chk=1 the expected prediction and the
    // pre-edge statistics are queued for the monitor. The statistics model
    // then advances for this edge.
    task automatic step(input logic rst, input logic [31:0] p, input logic ib,
                        input logic [31:0] pp, input logic pib, input logic pw,
                        input logic ppt, input logic chk, input logic exp_pred);
        reset                = rst;
        pc                   = p;
        is_branch            = ib;
        past_pc              = pp;
        past_is_branch       = pib;
        past_wrong           = pw;
        past_predicted_taken = ppt;
        chk_v                = chk;
        if (chk) begin
            exp_q.push_back({tag_n[7:0], exp_pred, exp_bc, exp_mc});
            tag_n++;
        end
        if (rst) begin
            exp_bc = '0;
            exp_mc = '0;
        end else if (pib) begin
            exp_bc = exp_bc + 16'd1;
            if (pw) exp_mc = exp_mc + 16'd1;
        end
        @(posedge clock);
        #1;
        chk_v = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] p, input logic exp_pred);
        step(1'b0, p, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, exp_pred);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total  = 0;
        bad    = 0;
        tag_n  = 0;
        exp_bc = '0;
        exp_mc = '0;
        chk_v  = 1'b0;
        reset  = 1'b1;
        pc = '0; is_branch = 1'b0; past_pc = '0;
        past_is_branch = 1'b0; past_wrong = 1'b0; past_predicted_taken = 1'b0;
        @(posedge clock);
        #1;

        step(1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

        // After reset every index predicts not-taken
        for (int i = 0; i < 64; i++) lookup(32'(i), 1'b0);
        step(1'b0, 32'd5, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Train index 5 taken twice (predicted not-taken, wrong); lookup idx 6
        step(1'b0, 32'd6, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd6, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        lookup(32'd5, 1'b1);
        lookup(32'd6, 1'b0);
        lookup(32'd69, 1'b1);
        lookup(32'hFFFF_FFC5, 1'b1);
        step(1'b0, 32'd5, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0);

        // Saturate index 3 with 10 taken updates, then walk it back down
        for (int i = 0; i < 10; i++)
            step(1'b0, 32'd4, 1'b1, 32'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        lookup(32'd3, 1'b1);
        step(1'b0, 32'd3, 1'b1, 32'd3, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        lookup(32'd3, 1'b1);
        step(1'b0, 32'd3, 1'b1, 32'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        lookup(32'd3, 1'b0);

        // Floor saturation at index 9: three not-taken, then two taken
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'd10, 1'b1, 32'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd9, 1'b1, 32'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 32'd9, 1'b1, 32'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);

        // Bypass at index 7 through an aliasing past_pc (71)
        lookup(32'd7, 1'b0);
        step(1'b0, 32'd7, 1'b1, 32'd71, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        lookup(32'd7, 1'b1);
        step(1'b0, 32'd7, 1'b1, 32'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

        // Resolution fields ignored without past_is_branch
        for (int i = 0; i < 3; i++)
            step(1'b0, 32'd7, 1'b1, 32'd7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        lookup(32'd7, 1'b0);

        // Reset together with an update: update dropped, table and counts cleared
        step(1'b1, 32'd5, 1'b1, 32'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        lookup(32'd5, 1'b0);
        lookup(32'd3, 1'b0);
        lookup(32'd9, 1'b0);

        // Three branches, one mispredict
        step(1'b0, 32'd0, 1'b0, 32'd20, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 32'd21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 32'd0, 1'b0, 32'd22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        lookup(32'd20, 1'b1);

        // Second reset with a simultaneous update
        step(1'b1, 32'd7, 1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        lookup(32'd7, 1'b0);
        lookup(32'd20, 1'b0);
        step(1'b0, 32'd7, 1'b1, 32'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        lookup(32'd7, 1'b1);

        @(negedge clock);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
